// File: rtl/inst_fetch.sv
// Instruction-fetch stage: architectural PC plus a direct-mapped, one-word-per-line
// instruction cache that is filled from the memory controller and delivers {pc, inst, valid}.
module inst_fetch #(
  parameter int unsigned IDX_W    = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        br_flag_i,
  input  logic [31:0] br_target_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_pc_i,
  input  logic        inst_ok_i,
  output logic        inst_fe_o,
  output logic [31:0] nxt_pc_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o
);

  localparam int unsigned TAG_W = 32 - IDX_W - 2;
  localparam int unsigned LINES = 2 ** IDX_W;

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      if_pc_q, if_pc_d;
  logic [31:0]      if_inst_q, if_inst_d;
  logic             if_valid_q, if_valid_d;
  logic [LINES-1:0] valid_q, valid_d;

  logic [TAG_W-1:0] tag_mem_q  [LINES];
  logic [31:0]      data_mem_q [LINES];

  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             fill_en;
  logic             hit;
  logic             bypass;

  // Address split, lookup and the same-cycle bypass of a returning word.
  always_comb begin
    pc_idx   = pc_q[IDX_W+1:2];
    pc_tag   = pc_q[31:IDX_W+2];
    fill_idx = inst_pc_i[IDX_W+1:2];
    fill_tag = inst_pc_i[31:IDX_W+2];
    fill_en  = inst_ok_i & ~rst;
    hit      = valid_q[pc_idx] && (tag_mem_q[pc_idx] == pc_tag);
    bypass   = inst_ok_i && (inst_pc_i == pc_q);
  end

  // nxt_pc_o always shows pc so the controller's sequential prefetch keeps working.
  assign inst_fe_o  = ~rst & ~hit & ~bypass;
  assign nxt_pc_o   = pc_q;
  assign if_pc_o    = if_pc_q;
  assign if_inst_o  = if_inst_q;
  assign if_valid_o = if_valid_q;

  // Valid-bit update: every accepted return fills its line, stalled or not.
  always_comb begin
    valid_d = valid_q;
    if (fill_en) begin
      valid_d[fill_idx] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // PC and delivery registers: redirect beats stall, stall beats delivery.
  always_comb begin
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    if (br_flag_i) begin
      pc_d       = br_target_i & 32'hFFFF_FFFC;
      if_valid_d = 1'b0;
    end else if (stall_i) begin
      pc_d       = pc_q;
      if_valid_d = if_valid_q;
    end else if (hit || bypass) begin
      if_pc_d    = pc_q;
      if_inst_d  = bypass ? inst_i : data_mem_q[pc_idx];
      if_valid_d = 1'b1;
      pc_d       = pc_q + 32'd4;
    end else begin
      if_valid_d = 1'b0;
    end
  end

  // Architectural state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      if_pc_q    <= 32'h0000_0000;
      if_inst_q  <= 32'h0000_0000;
      if_valid_q <= 1'b0;
      valid_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
      valid_q    <= valid_d;
    end
  end

  // Tag/data storage needs no reset: the valid bits gate every read.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem_q[fill_idx]  <= fill_tag;
      data_mem_q[fill_idx] <= inst_i;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch: cold miss/bypass, hits, stall,
// redirect during a miss, index aliasing, PC wrap and asynchronous reset mid-miss.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        br_flag_i;
  logic [31:0] br_target_i;
  logic [31:0] inst_i;
  logic [31:0] inst_pc_i;
  logic        inst_ok_i;
  logic        inst_fe_o;
  logic [31:0] nxt_pc_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;

  int n_cmp;
  int n_err;

  inst_fetch #(.IDX_W(6), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .br_flag_i   (br_flag_i),
    .br_target_i (br_target_i),
    .inst_i      (inst_i),
    .inst_pc_i   (inst_pc_i),
    .inst_ok_i   (inst_ok_i),
    .inst_fe_o   (inst_fe_o),
    .nxt_pc_o    (nxt_pc_o),
    .if_pc_o     (if_pc_o),
    .if_inst_o   (if_inst_o),
    .if_valid_o  (if_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    br_flag_i   = 1'b1;
    br_target_i = tgt;
    tick();
    br_flag_i   = 1'b0;
  endtask

  // Return a word whose address equals the current pc, so it is delivered.
  task automatic ret_word(input logic [31:0] a, input logic [31:0] d);
    inst_ok_i = 1'b1;
    inst_pc_i = a;
    inst_i    = d;
    tick();
    inst_ok_i = 1'b0;
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst         = 1'b1;
    stall_i     = 1'b0;
    br_flag_i   = 1'b0;
    br_target_i = 32'h0;
    inst_i      = 32'h0;
    inst_pc_i   = 32'h0;
    inst_ok_i   = 1'b0;

    // Reset state
    #3;
    check("rst_fe",    {31'd0, inst_fe_o}, 32'd0);
    check("rst_valid", {31'd0, if_valid_o}, 32'd0);
    check("rst_pc",    if_pc_o, 32'd0);
    check("rst_inst",  if_inst_o, 32'd0);
    check("rst_nxt",   nxt_pc_o, 32'd0);
    tick();
    tick();
    #2;
    rst = 1'b0;
    settle();
    check("cold_fe",  {31'd0, inst_fe_o}, 32'd1);
    check("cold_nxt", nxt_pc_o, 32'd0);

    // Cold miss served by bypass
    inst_ok_i = 1'b1;
    inst_pc_i = 32'h0;
    inst_i    = 32'h0000_0013;
    settle();
    check("byp_fe", {31'd0, inst_fe_o}, 32'd0);
    tick();
    inst_ok_i = 1'b0;
    settle();
    check("byp_valid", {31'd0, if_valid_o}, 32'd1);
    check("byp_pc",    if_pc_o, 32'h0);
    check("byp_inst",  if_inst_o, 32'h13);
    check("byp_nxt",   nxt_pc_o, 32'h4);
    check("miss4_fe",  {31'd0, inst_fe_o}, 32'd1);

    // Fill 4, 8, C
    for (int i = 1; i < 4; i++) begin
      ret_word(32'(4 * i), 32'h1000 + 32'(i));
      check("fill_pc", if_pc_o, 32'(4 * i));
    end
    check("fill_nxt", nxt_pc_o, 32'h10);

    // Back-to-back hits after redirect to 0
    redirect(32'h0);
    check("redir_valid", {31'd0, if_valid_o}, 32'd0);
    check("redir_nxt",   nxt_pc_o, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("hit_fe", {31'd0, inst_fe_o}, 32'd0);
      tick();
      check("hit_pc",    if_pc_o, 32'(4 * i));
      check("hit_valid", {31'd0, if_valid_o}, 32'd1);
      check("hit_inst",  if_inst_o, (i == 0) ? 32'h13 : 32'h1000 + 32'(i));
    end
    check("hit_end_fe", {31'd0, inst_fe_o}, 32'd1);

    // Stall while hitting, then redirect during stall
    redirect(32'h0);
    tick();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc",    if_pc_o, 32'h0);
      check("stall_inst",  if_inst_o, 32'h13);
      check("stall_valid", {31'd0, if_valid_o}, 32'd1);
      check("stall_nxt",   nxt_pc_o, 32'h4);
    end
    redirect(32'h0000_000B);
    check("stbr_valid", {31'd0, if_valid_o}, 32'd0);
    check("stbr_nxt",   nxt_pc_o, 32'h8);
    stall_i = 1'b0;
    tick();
    check("stbr_pc",   if_pc_o, 32'h8);
    check("stbr_inst", if_inst_o, 32'h1002);

    // Redirect during an outstanding miss
    redirect(32'h100);
    check("rdm_nxt1", nxt_pc_o, 32'h100);
    check("rdm_fe1",  {31'd0, inst_fe_o}, 32'd1);
    tick();
    check("rdm_miss_valid", {31'd0, if_valid_o}, 32'd0);
    redirect(32'h200);
    check("rdm_nxt2", nxt_pc_o, 32'h200);
    inst_ok_i = 1'b1;
    inst_pc_i = 32'h100;
    inst_i    = 32'h0000_AAAA;
    settle();
    check("stale_fe", {31'd0, inst_fe_o}, 32'd1);
    tick();
    inst_ok_i = 1'b0;
    check("stale_valid", {31'd0, if_valid_o}, 32'd0);
    check("stale_nxt",   nxt_pc_o, 32'h200);
    redirect(32'h100);
    check("stale_hit_fe", {31'd0, inst_fe_o}, 32'd0);
    tick();
    check("stale_hit_valid", {31'd0, if_valid_o}, 32'd1);
    check("stale_hit_pc",    if_pc_o, 32'h100);
    check("stale_hit_inst",  if_inst_o, 32'hAAAA);

    // Index aliasing: 0x000 and 0x100 share line 0
    redirect(32'h0);
    check("alias0_fe", {31'd0, inst_fe_o}, 32'd1);
    ret_word(32'h0, 32'h13);
    check("alias0_inst", if_inst_o, 32'h13);
    redirect(32'h100);
    check("alias1_fe", {31'd0, inst_fe_o}, 32'd1);
    ret_word(32'h100, 32'h0000_BBBB);
    check("alias1_inst", if_inst_o, 32'hBBBB);
    redirect(32'h0);
    check("alias0_again_fe", {31'd0, inst_fe_o}, 32'd1);

    // PC wrap at the top of the address space
    redirect(32'hFFFF_FFFC);
    ret_word(32'hFFFF_FFFC, 32'h77);
    check("wrap_pc",    if_pc_o, 32'hFFFF_FFFC);
    check("wrap_inst",  if_inst_o, 32'h77);
    check("wrap_valid", {31'd0, if_valid_o}, 32'd1);
    check("wrap_nxt",   nxt_pc_o, 32'h0);
    check("wrap_fe",    {31'd0, inst_fe_o}, 32'd1);

    // Async reset mid-miss, with a return arriving while reset is held
    #2;
    rst = 1'b1;
    settle();
    check("arst_fe",    {31'd0, inst_fe_o}, 32'd0);
    check("arst_valid", {31'd0, if_valid_o}, 32'd0);
    check("arst_pc",    if_pc_o, 32'd0);
    check("arst_inst",  if_inst_o, 32'd0);
    check("arst_nxt",   nxt_pc_o, 32'd0);
    inst_ok_i = 1'b1;
    inst_pc_i = 32'h0;
    inst_i    = 32'h0000_DEAD;
    tick();
    inst_ok_i = 1'b0;
    rst       = 1'b0;
    settle();
    check("post_rst_fe",  {31'd0, inst_fe_o}, 32'd1);
    check("post_rst_nxt", nxt_pc_o, 32'd0);
    tick();
    check("post_rst_valid", {31'd0, if_valid_o}, 32'd0);
    redirect(32'h4);
    check("post_rst_cold4", {31'd0, inst_fe_o}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
